count_display_driver: RTL and testbench

Downstream consumer of the 6-bit free-running counter output (`count_o`, 0–63).
- Converts the binary count to two BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Multiplexes the two digits onto a 2-digit 7-segment display at a programmable refresh rate.
- Sits between the counter and the board display pins.

---
 rtl/count_display_driver.sv | 155 +++++++++++++++
 tb/tb_count_display_driver.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/count_display_driver.sv
// Converts a 6-bit binary count to two BCD digits with a sequential double-dabble
// engine and multiplexes them onto a 2-digit 7-segment display.
module count_display_driver #(
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LEADING  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] count_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o,
    output logic       bcd_valid_o,
    output logic       busy_o,
    output logic [6:0] seg_o,
    output logic [1:0] an_o
);

    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CONVERT = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    function automatic logic [7:0] add3(input logic [7:0] bcd);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = (bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4];
        lo = (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0];
        return {hi, lo};
    endfunction

    // Active-high gfedcba pattern; out-of-range codes light nothing.
    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [6:0] seg_drive(input logic [6:0] lit);
        return SEG_ACTIVE_LOW ? ~lit : lit;
    endfunction

    logic [1:0]    state_q, state_d;
    logic [5:0]    last_q, last_d;
    logic [13:0]   shift_q, shift_d;
    logic [2:0]    iter_q, iter_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic          valid_q, valid_d;
    logic [RW-1:0] refresh_q, refresh_d;
    logic          sel_q, sel_d;
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    an_q, an_d;
    logic [13:0]   adj_w;

    assign adj_w = {add3(shift_q[13:6]), shift_q[5:0]};

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        shift_d = shift_q;
        iter_d  = iter_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_i != last_q) begin
                    shift_d = {8'h00, count_i};
                    last_d  = count_i;
                    iter_d  = 3'd0;
                    state_d = S_CONVERT;
                end
            end
            S_CONVERT: begin
                shift_d = adj_w << 1;
                iter_d  = iter_q + 3'd1;
                if (iter_q == 3'd5) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                tens_d  = shift_q[13:10];
                ones_d  = shift_q[9:6];
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Display refresh is free-running and independent of the converter.
    always_comb begin
        refresh_d = (refresh_q == REFRESH_LAST) ? '0 : refresh_q + RW'(1);
        sel_d     = (refresh_q == REFRESH_LAST) ? ~sel_q : sel_q;
        if (sel_q) begin
            an_d  = 2'b01;
            seg_d = (BLANK_LEADING && (tens_q == 4'd0)) ? SEG_OFF : seg_drive(seg_encode(tens_q));
        end else begin
            an_d  = 2'b10;
            seg_d = seg_drive(seg_encode(ones_q));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            last_q    <= 6'd0;
            tens_q    <= 4'd0;
            ones_q    <= 4'd0;
            valid_q   <= 1'b0;
            refresh_q <= '0;
            sel_q     <= 1'b0;
            seg_q     <= SEG_OFF;
            an_q      <= 2'b11;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            valid_q   <= valid_d;
            refresh_q <= refresh_d;
            sel_q     <= sel_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    // Shift register and iteration count are always reloaded on entry to CONVERT.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        iter_q  <= iter_d;
    end

    assign tens_o      = tens_q;
    assign ones_o      = ones_q;
    assign bcd_valid_o = valid_q;
    assign busy_o      = (state_q != S_IDLE);
    assign seg_o       = seg_q;
    assign an_o        = an_q;

endmodule

// File: tb/tb_count_display_driver.sv
// Directed bench for count_display_driver with a BCD scoreboard fed at stimulus time.
module tb_count_display_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] count_i;
    logic [3:0] tens_o;
    logic [3:0] ones_o;
    logic       bcd_valid_o;
    logic       busy_o;
    logic [6:0] seg_o;
    logic [1:0] an_o;

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    logic [7:0] sb[$];

    count_display_driver #(
        .REFRESH_DIV(4),
        .SEG_ACTIVE_LOW(1'b1),
        .BLANK_LEADING(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .count_i(count_i),
        .tens_o(tens_o),
        .ones_o(ones_o),
        .bcd_valid_o(bcd_valid_o),
        .busy_o(busy_o),
        .seg_o(seg_o),
        .an_o(an_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_an(input logic [1:0] target);
        bit found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (an_o === target) found = 1;
            else tick();
        end
        check("wait_an", 16'(an_o), 16'(target));
    endtask

    task automatic wait_valid(input string tag);
        bit found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (bcd_valid_o === 1'b1) found = 1;
        end
        check(tag, 16'(found), 16'd1);
    endtask

    // Scoreboard consumer: every valid pulse must match the oldest pending result.
    always @(negedge clk) begin
        if (rst === 1'b1 && bcd_valid_o === 1'b1) begin
            pulses++;
            if (sb.size() == 0) begin
                check("sb_unexpected_pulse", 16'd1, 16'd0);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                check("sb_bcd", 16'({tens_o, ones_o}), 16'(e));
            end
        end
    end

    initial begin
        int n;
        rst = 1'b0;
        count_i = 6'd0;
        repeat (3) tick();
        check("rst_an", 16'(an_o), 16'h3);
        check("rst_seg", 16'(seg_o), 16'h7F);
        check("rst_tens", 16'(tens_o), 16'd0);
        check("rst_ones", 16'(ones_o), 16'd0);
        check("rst_valid", 16'(bcd_valid_o), 16'd0);
        check("rst_busy", 16'(busy_o), 16'd0);

        // Idle display with count 0: ones shows "0", tens blank, 4 cycles per slot.
        rst = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if ((((k - 1) / 4) % 2) == 0) begin
                check("idle_an_ones", 16'(an_o), 16'h2);
                check("idle_seg_ones", 16'(seg_o), 16'(7'b1000000));
            end else begin
                check("idle_an_tens", 16'(an_o), 16'h1);
                check("idle_seg_tens", 16'(seg_o), 16'(7'b1111111));
            end
            check("idle_busy", 16'(busy_o), 16'd0);
        end

        // 42: busy for 7 cycles, then a single valid pulse.
        count_i = 6'd42;
        sb.push_back(8'h42);
        tick();
        n = 0;
        while (busy_o === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        check("busy_len_42", 16'(n), 16'd7);
        check("valid_42", 16'(bcd_valid_o), 16'd1);
        check("tens_42", 16'(tens_o), 16'd4);
        check("ones_42", 16'(ones_o), 16'd2);
        tick();
        check("valid_42_drop", 16'(bcd_valid_o), 16'd0);
        wait_an(2'b01);
        check("seg_tens_4", 16'(seg_o), 16'(7'b0011001));
        wait_an(2'b10);
        check("seg_ones_2", 16'(seg_o), 16'(7'b0100100));

        count_i = 6'd63;
        sb.push_back(8'h63);
        wait_valid("wait_63");
        check("tens_63", 16'(tens_o), 16'd6);
        check("ones_63", 16'(ones_o), 16'd3);
        tick();
        wait_an(2'b01);
        check("seg_tens_6", 16'(seg_o), 16'(7'b0000010));

        count_i = 6'd7;
        sb.push_back(8'h07);
        wait_valid("wait_7");
        tick();
        wait_an(2'b01);
        check("seg_tens_blank", 16'(seg_o), 16'(7'b1111111));
        wait_an(2'b10);
        check("seg_ones_7", 16'(seg_o), 16'(7'b1111000));

        // Full sweep.
        pulses = 0;
        for (int v = 0; v < 64; v++) begin
            count_i = 6'(v);
            sb.push_back({4'(v / 10), 4'(v % 10)});
            repeat (10) tick();
            check("sweep_tens", 16'(tens_o), 16'(v / 10));
            check("sweep_ones", 16'(ones_o), 16'(v % 10));
        end
        repeat (10) tick();
        check("sweep_pulses", 16'(pulses), 16'd64);

        // Input change mid-conversion is picked up by a second conversion.
        pulses = 0;
        count_i = 6'd12;
        sb.push_back(8'h12);
        repeat (3) tick();
        count_i = 6'd35;
        sb.push_back(8'h35);
        repeat (30) tick();
        check("retrigger_pulses", 16'(pulses), 16'd2);
        check("retrigger_tens", 16'(tens_o), 16'd3);
        check("retrigger_ones", 16'(ones_o), 16'd5);

        // Reset at E4 of a conversion of 50 aborts it.
        pulses = 0;
        count_i = 6'd50;
        repeat (4) tick();
        check("abort_busy_before", 16'(busy_o), 16'd1);
        rst = 1'b0;
        tick();
        check("abort_tens", 16'(tens_o), 16'd0);
        check("abort_ones", 16'(ones_o), 16'd0);
        check("abort_an", 16'(an_o), 16'h3);
        check("abort_seg", 16'(seg_o), 16'h7F);
        check("abort_busy", 16'(busy_o), 16'd0);
        tick();
        check("abort_valid", 16'(bcd_valid_o), 16'd0);
        check("abort_pulses", 16'(pulses), 16'd0);
        rst = 1'b1;
        sb.push_back(8'h50);
        wait_valid("wait_50");
        check("restart_tens", 16'(tens_o), 16'd5);
        check("restart_ones", 16'(ones_o), 16'd0);
        repeat (5) tick();
        check("sb_drained", 16'(sb.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
